// File: rtl/acm_scrub_ctrl_pkg.sv
// Shared encodings for the register-file scrub controller (ACM).
// Holds the settings codes, the scrub address range and the controller state type.
package p_hardisc;

   localparam logic [1:0] ACM_OFF    = 2'b00;
   localparam logic [1:0] ACM_DETECT = 2'b01;
   localparam logic [1:0] ACM_FIX    = 2'b10;   // 2'b11 also selects detect-and-fix

   localparam logic [4:0] ACM_ADD_FIRST = 5'd1;
   localparam logic [4:0] ACM_ADD_LAST  = 5'd31;

   typedef enum logic {
      ACM_SCAN,
      ACM_FIX_REQ
   } acm_state;

   function automatic logic [4:0] acm_next_add(input logic [4:0] add);
      return (add == ACM_ADD_LAST) ? ACM_ADD_FIRST : add + 5'd1;
   endfunction

endpackage

// File: rtl/acm_scrub_ctrl.sv
// Background scrubber for the register file: borrows idle read ports to re-read
// entries x1..x31, counts replica/ECC mismatches and requests rewrites.
module acm_scrub_ctrl
   import p_hardisc::*;
(
   input  logic       s_clk_i,
   input  logic       s_resetn_i,
   input  logic [1:0] s_acm_settings_i,
   input  logic [1:0] s_free_rp_i,
   input  logic       s_flush_i,
   input  logic [1:0] s_rp_err_i,
   output logic [4:0] s_acm_add_o,
   output logic [1:0] s_acm_port_o,
   output logic       s_fix_req_o,
   output logic [4:0] s_fix_add_o,
   input  logic       s_fix_gnt_i,
   output logic [7:0] s_err_cnt_o,
   output logic       s_scan_done_o
);

   acm_state   state_q, state_d;
   logic [4:0] add_q, add_d;
   logic       inf_valid_q, inf_valid_d;
   logic [4:0] inf_add_q, inf_add_d;
   logic [1:0] inf_port_q, inf_port_d;
   logic [4:0] fix_add_q, fix_add_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       detect;
   logic       issue;
   logic [1:0] grant;

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q     <= ACM_SCAN;
         add_q       <= ACM_ADD_FIRST;
         inf_valid_q <= 1'b0;
         inf_add_q   <= '0;
         inf_port_q  <= '0;
         fix_add_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         add_q       <= add_d;
         inf_valid_q <= inf_valid_d;
         inf_add_q   <= inf_add_d;
         inf_port_q  <= inf_port_d;
         fix_add_q   <= fix_add_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      add_d     = add_q;
      fix_add_d = fix_add_q;
      err_cnt_d = err_cnt_q;
      grant     = '0;

      // A flushed read is discarded, so its error flag is not meaningful.
      detect = inf_valid_q && !s_flush_i && ((s_rp_err_i & inf_port_q) != 2'b00);

      // Gated by reset so the grant stays quiet while the block is held in reset.
      issue = s_resetn_i && (state_q == ACM_SCAN) && (s_acm_settings_i != ACM_OFF)
              && (s_free_rp_i != 2'b00) && !detect && !s_flush_i;

      if (issue)
         grant = s_free_rp_i[0] ? 2'b01 : 2'b10;

      if (detect && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;

      case (state_q)
         ACM_SCAN: begin
            if (detect && ((s_acm_settings_i & ACM_FIX) != 2'b00)) begin
               state_d   = ACM_FIX_REQ;
               fix_add_d = inf_add_q;
            end
         end
         ACM_FIX_REQ: begin
            if (s_fix_gnt_i)
               state_d = ACM_SCAN;
         end
         default: state_d = ACM_SCAN;
      endcase

      // Rewind to the flushed address so it is scrubbed again rather than skipped.
      if (s_flush_i && inf_valid_q)
         add_d = inf_add_q;
      else if (issue)
         add_d = acm_next_add(add_q);

      inf_valid_d = issue;
      inf_add_d   = add_q;
      inf_port_d  = grant;
   end

   assign s_acm_add_o   = add_q;
   assign s_acm_port_o  = grant;
   assign s_fix_req_o   = (state_q == ACM_FIX_REQ);
   assign s_fix_add_o   = fix_add_q;
   assign s_err_cnt_o   = err_cnt_q;
   assign s_scan_done_o = issue && (add_q == ACM_ADD_LAST);

endmodule

// File: tb/tb_acm_scrub_ctrl.sv
// Directed bench for acm_scrub_ctrl: expected outputs are queued as each step is
// driven and popped against the DUT at the following falling clock edge.
module tb_acm_scrub_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] settings;
   logic [1:0] free_rp;
   logic       flush;
   logic [1:0] rp_err;
   logic       fix_gnt;
   logic [4:0] acm_add;
   logic [1:0] acm_port;
   logic       fix_req;
   logic [4:0] fix_add;
   logic [7:0] err_cnt;
   logic       scan_done;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic [1:0] port;
      logic [4:0] add;
      logic       done;
      logic       freq;
      logic [4:0] fadd;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];

   logic [4:0] ea;    // next address the bench expects to be issued
   logic [4:0] efa;   // expected latched fix address
   int         ec;    // expected error count

   acm_scrub_ctrl dut (
      .s_clk_i          (clk),
      .s_resetn_i       (rst_n),
      .s_acm_settings_i (settings),
      .s_free_rp_i      (free_rp),
      .s_flush_i        (flush),
      .s_rp_err_i       (rp_err),
      .s_acm_add_o      (acm_add),
      .s_acm_port_o     (acm_port),
      .s_fix_req_o      (fix_req),
      .s_fix_add_o      (fix_add),
      .s_fix_gnt_i      (fix_gnt),
      .s_err_cnt_o      (err_cnt),
      .s_scan_done_o    (scan_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] nxt(input logic [4:0] a);
      return (a == 5'd31) ? 5'd1 : a + 5'd1;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] p, input logic [4:0] a, input logic d,
                       input logic fr, input logic [4:0] fa, input logic [7:0] c);
      exp_t e;
      e.port = p; e.add = a; e.done = d; e.freq = fr; e.fadd = fa; e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".port"}, {6'd0, acm_port},  {6'd0, e.port});
         chk({tag, ".add"},  {3'd0, acm_add},   {3'd0, e.add});
         chk({tag, ".done"}, {7'd0, scan_done}, {7'd0, e.done});
         chk({tag, ".freq"}, {7'd0, fix_req},   {7'd0, e.freq});
         chk({tag, ".fadd"}, {3'd0, fix_add},   {3'd0, e.fadd});
         chk({tag, ".cnt"},  err_cnt,           e.cnt);
      end
   endtask

   // Drive one cycle of inputs shortly after a rising edge, check at the falling edge.
   task automatic cyc(input string tag, input logic [1:0] s, input logic [1:0] f,
                      input logic fl, input logic [1:0] er, input logic g,
                      input logic [1:0] p, input logic [4:0] a, input logic d,
                      input logic fr, input logic [4:0] fa, input int c);
      settings = s; free_rp = f; flush = fl; rp_err = er; fix_gnt = g;
      push(p, a, d, fr, fa, c[7:0]);
      @(negedge clk);
      pop_compare(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; settings = 2'b01; free_rp = 2'b11; flush = 1'b0;
      rp_err = 2'b00; fix_gnt = 1'b0;
      ea = 5'd1; efa = 5'd0; ec = 0;

      repeat (3) @(posedge clk);
      #1;
      push(2'b00, 5'd1, 1'b0, 1'b0, 5'd0, 8'd0);
      pop_compare("reset_hold");
      rst_n = 1'b1;

      // Full sweep with both ports free: port 1 wins, pulse on 31, wrap to 1.
      for (int i = 1; i <= 31; i++) begin
         cyc("sweep", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, ea == 5'd31, 1'b0, efa, ec);
         ea = nxt(ea);
      end
      cyc("wrap", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);

      // Fix mode, port 2 only, error on address 7.
      while (ea != 5'd8) begin
         cyc("fix_scan", 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, ea, 1'b0, 1'b0, efa, ec);
         ea = nxt(ea);
      end
      cyc("fix_detect", 2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);
      ec = ec + 1; efa = 5'd7;
      cyc("fix_wait1", 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      cyc("fix_wait2_flush", 2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      cyc("fix_wait3", 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      cyc("fix_gnt", 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      cyc("fix_resume", 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);

      // Detect only, error on 12; a stray grant outside FIX_REQ must be ignored.
      while (ea != 5'd13) begin
         cyc("det_scan", 2'b01, 2'b01, 1'b0, 2'b00, ea == 5'd10, 2'b01, ea, 1'b0, 1'b0, efa, ec);
         ea = nxt(ea);
      end
      cyc("det_detect", 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);
      ec = ec + 1;
      cyc("det_resume", 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);

      // Flush after issuing 20: error ignored, 20 re-scrubbed.
      while (ea != 5'd21) begin
         cyc("fl_scan", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
         ea = nxt(ea);
      end
      cyc("fl_flush", 2'b01, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);
      ea = 5'd20;
      cyc("fl_rescrub", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);
      cyc("fl_next", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);

      // Switching off stops issue but the pending check is still counted.
      cyc("off_issue", 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, ea, 1'b0, 1'b0, efa, ec);
      ea = nxt(ea);
      cyc("off_detect", 2'b00, 2'b11, 1'b0, 2'b01, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);
      ec = ec + 1;
      cyc("off_idle", 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);

      // 300 further errors: counter must saturate.
      for (int i = 0; i < 300; i++) begin
         cyc("sat_issue", 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 2'b01, ea, ea == 5'd31, 1'b0, efa, ec);
         ea = nxt(ea);
         cyc("sat_detect", 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, ea, 1'b0, 1'b0, efa, ec);
         ec = (ec < 255) ? ec + 1 : 255;
      end
      cyc("sat_hold", 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, ea, ea == 5'd31, 1'b0, efa, ec);
      ea = nxt(ea);

      // Enter FIX_REQ, drop to detect-only, then pull reset mid-cycle.
      cyc("rst_issue", 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, ea, ea == 5'd31, 1'b0, efa, ec);
      efa = ea;
      ea = nxt(ea);
      cyc("rst_detect", 2'b10, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, ea, 1'b0, 1'b0, 5'd7, ec);
      cyc("rst_fixreq", 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      cyc("rst_fixhold", 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, ea, 1'b0, 1'b1, efa, ec);
      #2;
      rst_n = 1'b0;
      #1;
      push(2'b00, 5'd1, 1'b0, 1'b0, 5'd0, 8'd0);
      pop_compare("async_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
